// File: rtl/traffic_light_ctrl.sv
// Two-approach traffic light sequencer with an optional pedestrian walk phase.
// Define TLC_PED_EN to enable the pedestrian request latch and PED_WALK phase.
module traffic_light_ctrl #(
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int PED_CYC    = 10,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_B    = 3'd5,
        PED_WALK    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pending_q, ped_pending_d;

`ifndef TLC_PED_EN
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + 1'b1;
        ped_pending_d = 1'b0;
`ifdef TLC_PED_EN
        ped_pending_d = ped_pending_q | (ped_req && (state_q != PED_WALK));
`endif

        case (state_q)
            MAIN_GREEN: begin
                // Timer parks at the minimum so a late request still yields at once.
                if (timer_q == GREEN_LAST) begin
                    timer_d = timer_q;
                    if (side_req || ped_pending_q) state_d = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: if (timer_q == YELLOW_LAST) state_d = ALLRED_A;
            ALLRED_A: begin
                if (timer_q == ALLRED_LAST) begin
`ifdef TLC_PED_EN
                    state_d = ped_pending_q ? PED_WALK : SIDE_GREEN;
`else
                    state_d = SIDE_GREEN;
`endif
                end
            end
            SIDE_GREEN:  if (timer_q == GREEN_LAST)  state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (timer_q == YELLOW_LAST) state_d = ALLRED_B;
            PED_WALK:    if (timer_q == PED_LAST)    state_d = ALLRED_B;
            ALLRED_B:    if (timer_q == ALLRED_LAST) state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase

        if (state_d != state_q) timer_d = '0;
        // A request arriving on the entry edge is folded into this walk.
        if (state_d == PED_WALK && state_q != PED_WALK) ped_pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MAIN_GREEN;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        light      = LAMP_RED;
        side_light = LAMP_RED;
        ped_walk   = 1'b0;
        ped_ack    = 1'b0;
        phase      = state_q;
        case (state_q)
            MAIN_GREEN:  light      = LAMP_GREEN;
            MAIN_YELLOW: light      = LAMP_YELLOW;
            SIDE_GREEN:  side_light = LAMP_GREEN;
            SIDE_YELLOW: side_light = LAMP_YELLOW;
            default: ;
        endcase
`ifdef TLC_PED_EN
        ped_walk = (state_q == PED_WALK);
        ped_ack  = (state_q == PED_WALK) && (timer_q == '0);
`endif
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed timing scenarios plus
// randomized requests checked against a phase/age reference model.
module tb_traffic_light_ctrl;

    localparam int G  = 20;
    localparam int Y  = 4;
    localparam int AR = 2;
    localparam int PW = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] light, side_light, phase;
    logic       ped_walk, ped_ack;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: current phase number and cycles spent in it so far.
    int m_phase = 0;
    int m_age = 0;
    bit m_pend = 0;

    traffic_light_ctrl #(
        .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(AR), .PED_CYC(PW), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .side_req(side_req), .ped_req(ped_req),
        .light(light), .side_light(side_light), .ped_walk(ped_walk),
        .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic int dur_of(int p);
        case (p)
            1, 4:    return Y;
            2, 5:    return AR;
            6:       return PW;
            default: return G;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(int p);
        if (p == 0) return 3'b001;
        if (p == 1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] side_lamp(int p);
        if (p == 3) return 3'b001;
        if (p == 4) return 3'b010;
        return 3'b100;
    endfunction

    function automatic void model_step(bit rst, bit side, bit ped);
        bit leave;
        int nxt;
        bit pend;
        if (rst) begin
            m_phase = 0; m_age = 0; m_pend = 0;
            return;
        end
        if (m_phase == 0) leave = (m_age >= G - 1) && (side || m_pend);
        else              leave = (m_age == dur_of(m_phase) - 1);
        case (m_phase)
            0: nxt = 1;
            1: nxt = 2;
            2: nxt = m_pend ? 6 : 3;
            3: nxt = 4;
            4: nxt = 5;
            6: nxt = 5;
            default: nxt = 0;
        endcase
        pend = 0;
`ifdef TLC_PED_EN
        pend = m_pend || (ped && m_phase != 6);
        if (leave && nxt == 6) pend = 0;
`endif
        m_pend = pend;
        if (leave) begin m_phase = nxt; m_age = 0; end
        else m_age++;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(reset, side_req, ped_req);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; side_req = 1'b0; ped_req = 1'b0;
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (light !== 3'b001) begin errors++; $display("FAIL reset_light got=%b exp=001", light); end
        if (side_light !== 3'b100) begin errors++; $display("FAIL reset_side got=%b exp=100", side_light); end
        if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        if (ped_walk !== 1'b0) begin errors++; $display("FAIL reset_walk got=%b exp=0", ped_walk); end
        if (ped_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ped_ack); end
        for (int c = 0; c < 200; c++) begin
            tick();
            checks++;
            if (light !== 3'b001 || side_light !== 3'b100 || phase !== 3'd0) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got=%b/%b/%0d exp=001/100/0", cyc, light, side_light, phase);
            end
        end
        // Timer must still sit at its saturated value: yield is immediate.
        side_req = 1'b1;
        tick();
        checks++;
        if (phase !== 3'd1) begin errors++; $display("FAIL saturate_yield got=%0d exp=1", phase); end
        $display("test_reset done at cyc %0d", cyc);
    endtask

    task automatic test_side_seq();
        int ep;
        do_reset();
        side_req = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            if      (c < 20) ep = 0;
            else if (c < 24) ep = 1;
            else if (c < 26) ep = 2;
            else if (c < 46) ep = 3;
            else if (c < 50) ep = 4;
            else if (c < 52) ep = 5;
            else             ep = 0;
            checks++;
            if (phase !== 3'(ep) || light !== main_lamp(ep) || side_light !== side_lamp(ep)) begin
                errors++;
                $display("FAIL side_seq cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, phase, light, side_light,
                         ep, main_lamp(ep), side_lamp(ep));
            end
            tick();
        end
        $display("test_side_seq done");
    endtask

`ifdef TLC_PED_EN
    task automatic test_ped();
        int ep;
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            ped_req = (c == 3 || c == 30);
            if      (c < 20) ep = 0;
            else if (c < 24) ep = 1;
            else if (c < 26) ep = 2;
            else if (c < 36) ep = 6;
            else if (c < 38) ep = 5;
            else             ep = 0;
            checks++;
            if (phase !== 3'(ep) || ped_walk !== (c >= 26 && c <= 35) || ped_ack !== (c == 26)) begin
                errors++;
                $display("FAIL ped_path cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, phase, ped_walk, ped_ack,
                         ep, (c >= 26 && c <= 35), (c == 26));
            end
            tick();
        end
        ped_req = 1'b0;
        $display("test_ped done");
    endtask

    task automatic test_priority();
        int ep;
        do_reset();
        side_req = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            ped_req = (c == 5);
            if      (c < 20) ep = 0;
            else if (c < 24) ep = 1;
            else if (c < 26) ep = 2;
            else if (c < 36) ep = 6;
            else if (c < 38) ep = 5;
            else if (c < 58) ep = 0;
            else if (c < 62) ep = 1;
            else if (c < 64) ep = 2;
            else             ep = 3;
            checks++;
            if (phase !== 3'(ep)) begin
                errors++;
                $display("FAIL priority cyc=%0d got=%0d exp=%0d", c, phase, ep);
            end
            tick();
        end
        ped_req = 1'b0;
        $display("test_priority done");
    endtask
`else
    task automatic test_no_ped();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            ped_req = (c == 3 || c == 10 || c == 40);
            checks++;
            if (ped_walk !== 1'b0 || ped_ack !== 1'b0 || phase !== 3'd0 || light !== 3'b001) begin
                errors++;
                $display("FAIL no_ped cyc=%0d got=%b/%b/%0d/%b exp=0/0/0/001", c, ped_walk, ped_ack, phase, light);
            end
            tick();
        end
        ped_req = 1'b0;
        $display("test_no_ped done");
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        side_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ped_req = (c == 28);
            tick();
        end
        ped_req = 1'b0;
        checks++;
        if (phase !== 3'd3) begin errors++; $display("FAIL mid_pre_phase got=%0d exp=3", phase); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        side_req = 1'b0;
        checks++;
        if (phase !== 3'd0 || light !== 3'b001 || side_light !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset got=%0d/%b/%b exp=0/001/100", phase, light, side_light);
        end
        for (int c = 0; c < 120; c++) begin
            tick();
            checks++;
            if (phase !== 3'd0 || ped_walk !== 1'b0) begin
                errors++;
                $display("FAIL mid_dropped cyc=%0d got=%0d/%b exp=0/0", c, phase, ped_walk);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) side_req = ~side_req;
            ped_req = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 699) == 0);
            tick();
            got = {light, side_light, phase};
            exp = {main_lamp(m_phase), side_lamp(m_phase), 3'(m_phase)};
            checks++;
            if (got !== exp || ped_walk !== (m_phase == 6) || ped_ack !== (m_phase == 6 && m_age == 0)) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b/%b/%b exp=%b/%b/%b", c, got, ped_walk, ped_ack,
                         exp, (m_phase == 6), (m_phase == 6 && m_age == 0));
            end
        end
        reset = 1'b0; side_req = 1'b0; ped_req = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_side_seq();
`ifdef TLC_PED_EN
        test_ped();
        test_priority();
`else
        test_no_ped();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

- Sequencer that drives the `light[2:0]` traffic-signal datapath.
- Controls two approaches: main road (`light`) and side road (`side_light`).
- Main road rests on green; it yields to a side-road sensor request or a latched pedestrian request after a minimum green time.
- Sits between the road/pedestrian sensors and the lamp drivers. Its outputs are a pure decode of the state register.

## Interface
Parameters:
- `GREEN_CYC`, 20: main minimum green and fixed side green, in cycles.
- `YELLOW_CYC`, 4: yellow duration for either approach.
- `ALLRED_CYC`, 2: all-red clearance duration.
- `PED_CYC`, 10: pedestrian walk duration.
- `CNT_W`, 8: phase timer width. Every duration must be in 1..2^CNT_W.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `side_req`  input  1  side-road vehicle sensor (level).
- `ped_req`  input  1  pedestrian button (pulse or level).
- `light`  output  3  main-road lamps: bit2 red, bit1 yellow, bit0 green (exactly one-hot).
- `side_light`  output  3  side-road lamps, same encoding.
- `ped_walk`  output  1  walk indication.
- `ped_ack`  output  1  one-cycle pulse when a pedestrian request is served.
- `phase`  output  3  current state encoding, for debug.

## Operation
States, with their `phase` encoding:
- MAIN_GREEN=0
- MAIN_YELLOW=1
- ALLRED_A=2
- SIDE_GREEN=3
- SIDE_YELLOW=4
- ALLRED_B=5
- PED_WALK=6

Lamp decode:
- MAIN_GREEN: `light`=001, `side_light`=100.
- MAIN_YELLOW: `light`=010, `side_light`=100.
- SIDE_GREEN: `light`=100, `side_light`=001.
- SIDE_YELLOW: `light`=100, `side_light`=010.
- ALLRED_A, ALLRED_B, PED_WALK: both 100.
- `ped_walk`=1 only in PED_WALK.

Phase timer:
- Loads 0 on every state change and increments each cycle.
- A timed state exits in the cycle where timer==DUR-1, so the state lasts exactly DUR cycles.
- In MAIN_GREEN the timer saturates at GREEN_CYC-1.

Transitions:
- MAIN_GREEN → MAIN_YELLOW when timer==GREEN_CYC-1 and (`side_req` | ped_pending). Otherwise it holds indefinitely.
- MAIN_YELLOW → ALLRED_A after YELLOW_CYC.
- ALLRED_A → PED_WALK if ped_pending, else SIDE_GREEN, after ALLRED_CYC.
- SIDE_GREEN → SIDE_YELLOW after GREEN_CYC. Side green is fixed length and does not depend on `side_req`.
- SIDE_YELLOW → ALLRED_B after YELLOW_CYC.
- PED_WALK → ALLRED_B after PED_CYC.
- ALLRED_B → MAIN_GREEN after ALLRED_CYC.

ped_pending:
- Set when `ped_req`=1 in any state except PED_WALK.
- Cleared on the edge entering PED_WALK. A `ped_req` sampled on that same edge is absorbed; it counts as served.
- `ped_req` during PED_WALK is ignored.

ped_ack: asserted for exactly the first cycle of PED_WALK.

Priority:
- If both a side request and a pedestrian request are present, PED_WALK is served first.
- The side request is then served after the next MAIN_GREEN minimum.

## Timing
- Reset values:
  - state MAIN_GREEN, timer 0, ped_pending 0.
  - `light`=001, `side_light`=100, `ped_walk`=0, `ped_ack`=0, `phase`=0.
- Reset mid-operation: returns to the reset state on the next edge regardless of phase. Any pending request is dropped.
- Cycle numbering: cycle 0 is the first cycle after `reset` is deasserted. Outputs change in the cycle following the transition edge, with no extra pipeline stage.
- With `side_req` held at 1 from cycle 0, default parameters:
  - main green cycles 0–19
  - main yellow 20–23
  - ALLRED_A 24–25
  - side green 26–45
  - side yellow 46–49
  - ALLRED_B 50–51
  - main green from 52
- Pedestrian path, `ped_req` pulse at cycle 3, no side request:
  - PED_WALK cycles 26–35, with `ped_ack` at 26
  - ALLRED_B 36–37
  - main green from 38

## Configuration
Macro `TLC_PED_EN`:
- Defined: ped_pending register, PED_WALK state, `ped_walk` and `ped_ack` behave as specified.
- Undefined:
  - `ped_req` is ignored.
  - `ped_walk` and `ped_ack` are tied to 0.
  - PED_WALK is never entered.
  - ALLRED_A always proceeds to SIDE_GREEN.
  - MAIN_GREEN exits only on `side_req`.
  - Port list is unchanged.

## Test plan
- Reset, no requests for 200 cycles → `light`=001, `side_light`=100, `phase`=0 throughout; timer saturates without wrapping.
- `side_req`=1 from cycle 0 → phase sequence 0,1,2,3,4,5,0 with boundaries exactly at cycles 20, 24, 26, 46, 50, 52.
- `ped_req` pulse at cycle 3 → `ped_ack` only at cycle 26, `ped_walk`=1 in cycles 26–35, main green from 38. A second `ped_req` at cycle 30 is ignored: no further walk.
- `side_req`=1 and `ped_req` at cycle 5 → PED_WALK at cycle 26, main green at 38, then side green begins at cycle 38+20+4+2=64.
- `reset` asserted at cycle 30 (in SIDE_GREEN, with a pedestrian request pending) → next cycle `light`=001, `phase`=0, pending cleared; no walk follows without a new request.
- Build without `TLC_PED_EN`, `ped_req` pulsed → `ped_walk` and `ped_ack` stay 0; `phase` never equals 6; the main road holds green.
